// File: rtl/ball_controller.sv
// Pong ball engine: 1 px/axis/tick motion, wall and paddle reflection, miss
// detection, per-player scoring and IDLE/SERVE/PLAY/SCORED/OVER sequencing.
module ball_controller #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 200,
  parameter int START_X     = 316,
  parameter int START_Y     = 236,
  parameter int SERVE_DELAY = 60,
  parameter int MAX_SCORE   = 9
) (
  input  logic       game_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       p1_point,
  output logic       p2_point,
  output logic       game_over
);

  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] PW    = 11'(PADDLE_W);
  localparam logic [10:0] PH    = 11'(PADDLE_H);
  localparam logic [9:0]  CX    = 10'(START_X);
  localparam logic [9:0]  CY    = 10'(START_Y);
  localparam logic [3:0]  SMAX  = 4'(MAX_SCORE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;

  state_t        state_q, state_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic          dx_q, dx_d, dy_q, dy_d;   // dx 1=right, dy 1=down
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          pt1_q, pt1_d, pt2_q, pt2_d;
  logic          win_q, win_d;             // 1 = left player took the point

  logic [10:0] bx, by, p1x, p1y, p2x, p2y;
  logic        ov1, ov2;
  logic [3:0]  s1_inc, s2_inc;

  // Widen to 11 bits so x+BALL_SIZE style sums never wrap.
  assign bx  = {1'b0, bx_q};
  assign by  = {1'b0, by_q};
  assign p1x = {1'b0, p1_x};
  assign p1y = {1'b0, p1_y};
  assign p2x = {1'b0, p2_x};
  assign p2y = {1'b0, p2_y};
  assign ov1 = (by + BS > p1y) && (by < p1y + PH);
  assign ov2 = (by + BS > p2y) && (by < p2y + PH);
  assign s1_inc = (s1_q < SMAX) ? s1_q + 4'd1 : s1_q;
  assign s2_inc = (s2_q < SMAX) ? s2_q + 4'd1 : s2_q;

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    pt1_d   = 1'b0;
    pt2_d   = 1'b0;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        bx_d = CX;
        by_d = CY;
        if (start) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        bx_d = CX;
        by_d = CY;
        if (cnt_q == CNT_LAST) state_d = PLAY;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      PLAY: begin
        if (!dy_q && by == 11'd0) begin
          dy_d = 1'b1;
          by_d = 10'd1;
        end else if (dy_q && by == Y_MAX) begin
          dy_d = 1'b0;
          by_d = by_q - 10'd1;
        end else begin
          by_d = dy_q ? by_q + 10'd1 : by_q - 10'd1;
        end
        // Paddle faces are checked before the walls; a miss leaves x where it is.
        if (!dx_q && bx == p1x + PW && ov1) begin
          dx_d = 1'b1;
          bx_d = bx_q + 10'd1;
        end else if (dx_q && bx + BS == p2x && ov2) begin
          dx_d = 1'b0;
          bx_d = bx_q - 10'd1;
        end else if (!dx_q && bx == 11'd0) begin
          win_d   = 1'b0;
          state_d = SCORED;
        end else if (dx_q && bx == X_MAX) begin
          win_d   = 1'b1;
          state_d = SCORED;
        end else begin
          bx_d = dx_q ? bx_q + 10'd1 : bx_q - 10'd1;
        end
      end
      SCORED: begin
        bx_d  = CX;
        by_d  = CY;
        dx_d  = win_q;
        cnt_d = '0;
        if (win_q) begin
          s1_d    = s1_inc;
          pt1_d   = 1'b1;
          state_d = (s1_inc == SMAX) ? OVER : SERVE;
        end else begin
          s2_d    = s2_inc;
          pt2_d   = 1'b1;
          state_d = (s2_inc == SMAX) ? OVER : SERVE;
        end
      end
      OVER: begin
        bx_d = CX;
        by_d = CY;
        if (start) begin
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge game_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bx_q    <= CX;
      by_q    <= CY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      pt1_q   <= 1'b0;
      pt2_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      pt1_q   <= pt1_d;
      pt2_q   <= pt2_d;
      win_q   <= win_d;
    end
  end

  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign p1_score  = s1_q;
  assign p2_score  = s2_q;
  assign p1_point  = pt1_q;
  assign p2_point  = pt2_q;
  assign game_over = (state_q == OVER);

endmodule
